// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam int          ITER      = 32;
    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_e;

    function automatic logic op_is_div(input logic [1:0] op_v);
        return op_v[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op_v);
        return ~op_v[0];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the datapath: shift-add for multiply, restoring
// subtract-compare-shift for divide. Purely combinational.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               is_div_i,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   opnd_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [WIDTH:0] sum_s;
    logic [WIDTH:0] upper_s;
    logic [WIDTH:0] diff_s;

    // Compute the next accumulator value for a single multiply or divide step.
    always_comb begin
        sum_s   = {1'b0, acc_i[2*WIDTH-1:WIDTH]}
                + (acc_i[0] ? {1'b0, opnd_i} : {(WIDTH+1){1'b0}});
        upper_s = acc_i[2*WIDTH-1:WIDTH-1];
        diff_s  = upper_s - {1'b0, opnd_i};
        if (is_div_i) begin
            // Negative trial difference means the divisor did not fit: restore.
            if (diff_s[WIDTH]) begin
                acc_o = {acc_i[2*WIDTH-2:0], 1'b0};
            end else begin
                acc_o = {diff_s[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
            end
        end else begin
            acc_o = {sum_s, acc_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO registers.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = muldiv_pkg::ITER
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wd,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(ITER);

    state_e             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, step_s, prod_s;
    logic [WIDTH-1:0]   opnd_q, opnd_d, a_q, a_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0]   quot_s, rem_s, abs_a_s, abs_b_s;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               negres_q, negres_d, negrem_q, negrem_d;
    logic               dz_q, dz_d;
    logic               busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
    logic               sgn_s, is_div_s;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? ({WIDTH{1'b0}} - v) : v;
    endfunction

    assign sgn_s    = op_is_signed(op);
    assign abs_a_s  = magnitude(a, sgn_s);
    assign abs_b_s  = magnitude(b, sgn_s);
    assign is_div_s = op_is_div(op_q);

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div_i (is_div_s),
        .acc_i    (acc_q),
        .opnd_i   (opnd_q),
        .acc_o    (step_s)
    );

    // Sign correction of the raw magnitude result, consumed in FIX.
    always_comb begin
        prod_s = negres_q ? ({(2*WIDTH){1'b0}} - acc_q) : acc_q;
        quot_s = negres_q ? ({WIDTH{1'b0}} - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
        rem_s  = negrem_q ? ({WIDTH{1'b0}} - acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
    end

    // Next-state, datapath and HI/LO update logic.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        a_d      = a_q;
        cnt_d    = cnt_q;
        negres_d = negres_q;
        negrem_d = negrem_q;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    op_d     = op;
                    a_d      = a;
                    cnt_d    = {CW{1'b0}};
                    negres_d = sgn_s & (a[WIDTH-1] ^ b[WIDTH-1]);
                    negrem_d = sgn_s & a[WIDTH-1];
                    dz_d     = op_is_div(op) && (b == {WIDTH{1'b0}});
                    // Multiply keeps the multiplier in the low half; divide the dividend.
                    if (op_is_div(op)) begin
                        acc_d  = {{WIDTH{1'b0}}, abs_a_s};
                        opnd_d = abs_b_s;
                    end else begin
                        acc_d  = {{WIDTH{1'b0}}, abs_b_s};
                        opnd_d = abs_a_s;
                    end
                end else begin
                    hi_d = mthi ? wd : hi_q;
                    lo_d = mtlo ? wd : lo_q;
                end
            end
            RUN: begin
                acc_d = step_s;
                cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                if (cnt_q == CW'(ITER - 1)) begin
                    state_d = FIX;
                end else begin
                    state_d = RUN;
                end
            end
            FIX: begin
                state_d = DONE;
                if (!is_div_s) begin
                    hi_d = prod_s[2*WIDTH-1:WIDTH];
                    lo_d = prod_s[WIDTH-1:0];
                end else if (dz_q) begin
                    hi_d = a_q;
                    lo_d = DIV0_QUOT;
                end else begin
                    hi_d = rem_s;
                    lo_d = quot_s;
                end
            end
            DONE: begin
                state_d = IDLE;
                hi_d    = mthi ? wd : hi_q;
                lo_d    = mtlo ? wd : lo_q;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == RUN) || (state_d == FIX);
        done_d = (state_d == DONE);
        dbz_d  = (state_d == DONE) && dz_d;
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= 2'b00;
            acc_q    <= {(2*WIDTH){1'b0}};
            opnd_q   <= {WIDTH{1'b0}};
            a_q      <= {WIDTH{1'b0}};
            cnt_q    <= {CW{1'b0}};
            negres_q <= 1'b0;
            negrem_q <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= {WIDTH{1'b0}};
            lo_q     <= {WIDTH{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            a_q      <= a_d;
            cnt_q    <= cnt_d;
            negres_q <= negres_d;
            negrem_q <= negrem_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus random operations
// checked against an arithmetic reference model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst, start, mthi, mtlo;
    logic [1:0]  op;
    logic [31:0] a, b, wd;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_hi, exp_lo;

    muldiv_unit dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .mthi        (mthi),
        .mtlo        (mtlo),
        .wd          (wd),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference: MIPS semantics computed with plain 64-bit arithmetic.
    task automatic model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] eh, output logic [31:0] el, output logic ed);
        longint      sx, sy, q, r;
        logic [63:0] p, ux, uy;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        ux = {32'h0, x};
        uy = {32'h0, y};
        ed = 1'b0;
        eh = 32'h0;
        el = 32'h0;
        case (o)
            2'b00: begin p = sx * sy; eh = p[63:32]; el = p[31:0]; end
            2'b01: begin p = ux * uy; eh = p[63:32]; el = p[31:0]; end
            default: begin
                if (y == 32'h0) begin
                    eh = x; el = 32'hFFFF_FFFF; ed = 1'b1;
                end else if (o == 2'b10) begin
                    q = sx / sy; r = sx % sy;
                    el = q[31:0]; eh = r[31:0];
                end else begin
                    p = ux / uy; el = p[31:0];
                    p = ux % uy; eh = p[31:0];
                end
            end
        endcase
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input bit interfere, input bit mv_start);
        logic [31:0] eh, el;
        logic        ed;
        int          cyc, nb;
        bit          got;
        model(o, x, y, eh, el, ed);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        if (mv_start) begin mthi = 1'b1; mtlo = 1'b1; wd = 32'h5A5A_5A5A; end
        @(posedge clk);
        #1;
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
        cyc = 0; nb = 0; got = 1'b0;
        while (!got && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (busy) nb++;
            if (done) begin
                got = 1'b1;
            end else begin
                chk("hold_hi", {32'h0, hi}, {32'h0, exp_hi});
                chk("hold_lo", {32'h0, lo}, {32'h0, exp_lo});
            end
            if (interfere && cyc == 5) begin
                start = 1'b1; mthi = 1'b1; wd = 32'h1234_5678;
            end else if (interfere && cyc == 6) begin
                start = 1'b0; mthi = 1'b0;
            end
        end
        chk("done_seen", 64'(got), 64'd1);
        chk("latency", 64'(cyc), 64'd34);
        chk("busy_cycles", 64'(nb), 64'd33);
        chk("res_hi", {32'h0, hi}, {32'h0, eh});
        chk("res_lo", {32'h0, lo}, {32'h0, el});
        chk("res_dbz", 64'(div_by_zero), 64'(ed));
        exp_hi = eh;
        exp_lo = el;
        @(negedge clk);
        chk("done_pulse", 64'(done), 64'd0);
        chk("dbz_pulse", 64'(div_by_zero), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        bit          seen;
        rst = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        op = 2'b00; a = 32'h0; b = 32'h0; wd = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_hi", {32'h0, hi}, 64'd0);
        chk("rst_lo", {32'h0, lo}, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_dbz", 64'(div_by_zero), 64'd0);
        rst = 1'b0;
        exp_hi = 32'h0;
        exp_lo = 32'h0;

        run_op(2'b00, 32'hFFFF_FFFF, 32'd7, 1'b0, 1'b0);
        chk("mult_hi", {32'h0, exp_hi}, 64'h0000_0000_FFFF_FFFF);
        chk("mult_lo", {32'h0, lo}, 64'h0000_0000_FFFF_FFF9);

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        chk("multu_hi", {32'h0, hi}, 64'h0000_0000_FFFF_FFFE);

        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        chk("div_lo", {32'h0, lo}, 64'h0000_0000_FFFF_FFFD);
        chk("div_hi", {32'h0, hi}, 64'h0000_0000_FFFF_FFFF);

        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        chk("ovf_lo", {32'h0, lo}, 64'h0000_0000_8000_0000);

        run_op(2'b11, 32'd100, 32'd0, 1'b0, 1'b0);
        chk("dz_hi", {32'h0, hi}, 64'd100);

        // Start and mthi while running are both ignored.
        run_op(2'b00, 32'h0001_0003, 32'hFFFF_FF00, 1'b1, 1'b0);

        // MTLO in IDLE takes effect at the next edge.
        @(negedge clk);
        mtlo = 1'b1; wd = 32'hCAFE_BABE;
        @(posedge clk);
        #1;
        mtlo = 1'b0;
        @(negedge clk);
        chk("mtlo_lo", {32'h0, lo}, 64'h0000_0000_CAFE_BABE);
        chk("mtlo_hi", {32'h0, hi}, {32'h0, exp_hi});
        exp_lo = 32'hCAFE_BABE;

        // MTHI in IDLE.
        mthi = 1'b1; wd = 32'h0BAD_F00D;
        @(posedge clk);
        #1;
        mthi = 1'b0;
        @(negedge clk);
        chk("mthi_hi", {32'h0, hi}, 64'h0000_0000_0BAD_F00D);
        exp_hi = 32'h0BAD_F00D;

        // Start together with moves in IDLE: the moves are dropped.
        run_op(2'b11, 32'd1000, 32'd7, 1'b0, 1'b1);

        // Reset in RUN cycle 10 discards the operation.
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("pre_rst_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_hi", {32'h0, hi}, 64'd0);
        chk("mid_rst_lo", {32'h0, lo}, 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        exp_hi = 32'h0;
        exp_lo = 32'h0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("no_done_after_rst", 64'(seen), 64'd0);
        run_op(2'b01, 32'd3, 32'd5, 1'b0, 1'b0);
        chk("after_rst_lo", {32'h0, lo}, 64'd15);

        for (int i = 0; i < 12; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if (i % 4 == 3) rb = 32'h0;
            else if (i % 4 == 1) rb = 32'($urandom_range(1, 9));
            run_op(ro, ra, rb, 1'b0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
